// File: rtl/gpr_wb_pkg.sv
// rtl/gpr_wb_pkg.sv - shared widths, queue entry type and idle constant for gpr_writeback
package gpr_wb_pkg;

    localparam int GPR_XLEN = 32;
    localparam int GPR_NUM  = 32;
    localparam int RW       = $clog2(GPR_NUM);

    typedef struct packed {
        logic                live;
        logic [RW-1:0]       rd;
        logic [GPR_XLEN-1:0] data;
    } gpr_wb_entry_t;

    localparam gpr_wb_entry_t GPR_WB_IDLE = '{live: 1'b0, rd: '0, data: '0};

endpackage

// File: rtl/gpr_wb_fifo.sv
// rtl/gpr_wb_fifo.sv - circular load-result queue with per-entry squash of matching rd
module gpr_wb_fifo
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  gpr_wb_entry_t push_entry,
    input  logic          pop,
    input  logic          squash_valid,
    input  logic [RW-1:0] squash_rd,
    output gpr_wb_entry_t head,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    gpr_wb_entry_t r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    gpr_wb_entry_t w_in;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push in the same cycle as a matching ALU write is the older result, so it enters dead.
    always_comb begin
        w_in = push_entry;
        if (squash_valid && (push_entry.rd == squash_rd))
            w_in.live = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= GPR_WB_IDLE;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_valid && (r_mem[i].rd == squash_rd))
                    r_mem[i].live <= 1'b0;
            end
            if (push) begin
                r_mem[r_tail] <= w_in;
                r_tail        <= wrap_inc(r_tail);
            end
            if (pop)
                r_head <= wrap_inc(r_head);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign head  = r_mem[r_head];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/gpr_writeback.sv
// rtl/gpr_writeback.sv - ALU/LSU merge onto the GPR write port; GPR_WB_FWD_EN adds bypass ports
module gpr_writeback
    import gpr_wb_pkg::*;
#(
    parameter int XLEN  = GPR_XLEN,
    parameter int NUM   = GPR_NUM,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [$clog2(NUM)-1:0]   alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [$clog2(NUM)-1:0]   lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic [$clog2(NUM)-1:0]   gpr_addr_w,
    output logic [XLEN-1:0]          gpr_data_w,
    output logic                     lsu_pending
`ifdef GPR_WB_FWD_EN
    ,
    input  logic [$clog2(NUM)-1:0]   fwd_addr1,
    input  logic [$clog2(NUM)-1:0]   fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [XLEN-1:0]          fwd_data1,
    output logic [XLEN-1:0]          fwd_data2
`endif
);

    localparam int AW = $clog2(NUM);

    logic          w_full;
    logic          w_empty;
    logic          w_alu_acc;
    logic          w_pop;
    logic          w_push;
    logic          w_squash;
    gpr_wb_entry_t w_head;
    gpr_wb_entry_t w_push_entry;
    logic [AW-1:0]   w_nxt_addr;
    logic [XLEN-1:0] w_nxt_data;
    logic [AW-1:0]   r_addr;
    logic [XLEN-1:0] r_data;

    // A full queue always drains, which bounds how long ALU traffic can starve loads.
    assign alu_ready    = !w_full;
    assign w_alu_acc    = alu_valid && !w_full;
    assign w_pop        = w_full || (!alu_valid && !w_empty);
    assign lsu_ready    = !w_full || w_pop;
    assign w_push       = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign w_squash     = w_alu_acc && (alu_rd != '0);
    assign w_push_entry = '{live: 1'b1, rd: lsu_rd, data: lsu_data};

    gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .push         (w_push),
        .push_entry   (w_push_entry),
        .pop          (w_pop),
        .squash_valid (w_squash),
        .squash_rd    (alu_rd),
        .head         (w_head),
        .full         (w_full),
        .empty        (w_empty)
    );

    always_comb begin
        w_nxt_addr = '0;
        w_nxt_data = '0;
        if (w_alu_acc) begin
            w_nxt_addr = alu_rd;
            w_nxt_data = alu_data;
        end else if (w_pop && w_head.live) begin
            w_nxt_addr = w_head.rd;
            w_nxt_data = w_head.data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_addr <= w_nxt_addr;
            r_data <= w_nxt_data;
        end
    end

    assign gpr_addr_w  = r_addr;
    assign gpr_data_w  = r_data;
    assign lsu_pending = !w_empty;

`ifdef GPR_WB_FWD_EN
    // The register file returns stale data for the address being written this cycle.
    assign fwd_hit1  = (fwd_addr1 != '0) && (fwd_addr1 == r_addr);
    assign fwd_hit2  = (fwd_addr2 != '0) && (fwd_addr2 == r_addr);
    assign fwd_data1 = r_data;
    assign fwd_data2 = r_data;
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// tb/tb_gpr_writeback.sv - vector table plus scoreboard of expected register-file writes
module tb_gpr_writeback;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  gpr_addr_w;
    logic [31:0] gpr_data_w;
    logic        lsu_pending;
`ifdef GPR_WB_FWD_EN
    logic [4:0]  fwd_addr1;
    logic [4:0]  fwd_addr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    gpr_writeback #(.XLEN(32), .NUM(32), .DEPTH(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .gpr_addr_w  (gpr_addr_w),
        .gpr_data_w  (gpr_data_w),
        .lsu_pending (lsu_pending)
`ifdef GPR_WB_FWD_EN
        ,
        .fwd_addr1   (fwd_addr1),
        .fwd_addr2   (fwd_addr2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2)
`endif
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ear;
        logic        elr;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic        epend;
    } vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[20];
    wr_t  exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        wr_t  e;
        wr_t  g;
        v = vecs[i];
        drive(v.av, v.ard, v.ad, v.lv, v.lrd, v.ld);
        #1;
        chk($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(v.ear));
        chk($sformatf("v%0d lsu_ready", i), 64'(lsu_ready), 64'(v.elr));
        exp_q.push_back('{addr: v.eaddr, data: v.edata});
        @(posedge clock);
        #1;
        g = '{addr: gpr_addr_w, data: gpr_data_w};
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d scoreboard_empty", i), 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d write", i), 64'(g), 64'(e));
        end
        chk($sformatf("v%0d lsu_pending", i), 64'(lsu_pending), 64'(v.epend));
        @(negedge clock);
    endtask

    initial begin
        //          av    ard    ad        lv    lrd    ld        ear   elr   eaddr  edata     epend
        vecs[0]  = '{1'b1, 5'd5,  32'h11,  1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd5,  32'h11,  1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd0,  32'h0,   1'b0};
        vecs[2]  = '{1'b1, 5'd1,  32'h100, 1'b1, 5'd6,  32'h66, 1'b1, 1'b1, 5'd1,  32'h100, 1'b1};
        vecs[3]  = '{1'b1, 5'd2,  32'h200, 1'b1, 5'd7,  32'h77, 1'b1, 1'b1, 5'd2,  32'h200, 1'b1};
        vecs[4]  = '{1'b1, 5'd3,  32'h300, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 5'd6,  32'h66,  1'b1};
        vecs[5]  = '{1'b1, 5'd3,  32'h300, 1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd3,  32'h300, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd7,  32'h77,  1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,   1'b1, 5'd8,  32'hAA, 1'b1, 1'b1, 5'd0,  32'h0,   1'b1};
        vecs[8]  = '{1'b1, 5'd8,  32'hBB,  1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd8,  32'hBB,  1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd0,  32'h0,   1'b0};
        vecs[10] = '{1'b1, 5'd12, 32'hC1,  1'b1, 5'd12, 32'hC2, 1'b1, 1'b1, 5'd12, 32'hC1,  1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd0,  32'h0,   1'b0};
        vecs[12] = '{1'b1, 5'd0,  32'h44,  1'b1, 5'd0,  32'h55, 1'b1, 1'b1, 5'd0,  32'h44,  1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,   1'b1, 5'd0,  32'h66, 1'b1, 1'b1, 5'd0,  32'h0,   1'b0};
        vecs[14] = '{1'b1, 5'd1,  32'h1,   1'b1, 5'd13, 32'hD,  1'b1, 1'b1, 5'd1,  32'h1,   1'b1};
        vecs[15] = '{1'b1, 5'd2,  32'h2,   1'b1, 5'd14, 32'hE,  1'b1, 1'b1, 5'd2,  32'h2,   1'b1};
        vecs[16] = '{1'b1, 5'd3,  32'h3,   1'b1, 5'd15, 32'hF,  1'b0, 1'b1, 5'd13, 32'hD,   1'b1};
        vecs[17] = '{1'b1, 5'd3,  32'h3,   1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 5'd14, 32'hE,   1'b1};
        vecs[18] = '{1'b1, 5'd3,  32'h3,   1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd3,  32'h3,   1'b1};
        vecs[19] = '{1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd15, 32'hF,   1'b0};

        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef GPR_WB_FWD_EN
        fwd_addr1 = 5'd0;
        fwd_addr2 = 5'd0;
`endif
        repeat (2) @(negedge clock);
        chk("reset addr", 64'(gpr_addr_w), 64'(0));
        chk("reset data", 64'(gpr_data_w), 64'(0));
        chk("reset pending", 64'(lsu_pending), 64'(0));
        chk("reset alu_ready", 64'(alu_ready), 64'(1));
        chk("reset lsu_ready", 64'(lsu_ready), 64'(1));
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++)
            run_vec(i);

        // Queue two loads, then reset mid-cycle: nothing queued or staged may ever be written.
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20);
        @(posedge clock);
        @(negedge clock);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21);
        @(posedge clock);
        #1;
        chk("prereset pending", 64'(lsu_pending), 64'(1));
        chk("prereset addr", 64'(gpr_addr_w), 64'(2));
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset addr", 64'(gpr_addr_w), 64'(0));
        chk("midreset data", 64'(gpr_data_w), 64'(0));
        chk("midreset pending", 64'(lsu_pending), 64'(0));
        chk("midreset alu_ready", 64'(alu_ready), 64'(1));
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("postreset addr c%0d", k), 64'(gpr_addr_w), 64'(0));
            chk($sformatf("postreset pending c%0d", k), 64'(lsu_pending), 64'(0));
            @(negedge clock);
        end

`ifdef GPR_WB_FWD_EN
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        @(posedge clock);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        fwd_addr1 = 5'd5;
        fwd_addr2 = 5'd6;
        #1;
        chk("fwd_hit1", 64'(fwd_hit1), 64'(1));
        chk("fwd_data1", 64'(fwd_data1), 64'(32'h11));
        chk("fwd_hit2 other rd", 64'(fwd_hit2), 64'(0));
        fwd_addr2 = 5'd0;
        #1;
        chk("fwd_hit2 x0", 64'(fwd_hit2), 64'(0));
        @(negedge clock);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_writeback.md
# gpr_writeback

Write-side front end of the general-purpose register file. It merges results from the execute unit (ALU) and the load/store unit (LSU) into the register file's single write port (`addr_w`/`data_w`, write enabled by a nonzero address). Load results are buffered in a small queue. WAW ordering is preserved by squashing queued loads that a newer ALU write overtakes. The write port is driven from registers, so the register file commits one cycle after a result is accepted.

## Interface
- `XLEN`, 32, data width
- `NUM`, 32, number of GPRs; `RW = $clog2(NUM)`
- `DEPTH`, 2, LSU queue entries (≥1)

- `clock` in 1: sole clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `alu_valid` in 1: ALU result offered
- `alu_ready` out 1: ALU result accepted this cycle when high with `alu_valid`
- `alu_rd` in RW: ALU destination
- `alu_data` in XLEN: ALU result
- `lsu_valid` in 1: load result offered
- `lsu_ready` out 1: load result accepted this cycle when high with `lsu_valid`
- `lsu_rd` in RW: load destination
- `lsu_data` in XLEN: load data
- `gpr_addr_w` out RW: to register file write address; 0 = no write
- `gpr_data_w` out XLEN: to register file write data
- `lsu_pending` out 1: queue non-empty
- Forwarding ports exist only under `GPR_WB_FWD_EN` (see Configuration).

## Operation
- Queue is a FIFO of entries {live, rd, data}; occupancy ranges 0..DEPTH.
- Arbitration, once per cycle:
  - If the queue is full: the head drains, and `alu_ready`=0.
  - Otherwise, if `alu_valid`: the ALU wins (`alu_ready`=1) and the queue does not drain.
  - Otherwise the head drains, if present.
- `alu_ready` = !full, combinational, independent of `lsu_valid`.
- `lsu_ready` = !full OR (head drains this cycle). Push and pop in the same cycle when full is legal.
- An LSU result with `lsu_rd`==0 is accepted and discarded, not enqueued.
- An ALU result with `alu_rd`==0 is accepted, and the staged address is 0.
- Squash: an accepted ALU write with rd≠0 clears `live` on every queued entry with matching rd. It also clears `live` on an LSU entry pushed in the same cycle with matching rd, because a simultaneous LSU push counts as older.
- A drained dead entry stages address 0 (no write) and still frees its slot.
- Staged output register, updated every edge:
  - winner's {rd, data}, or
  - {0, 0} if there is no winner.

## Timing
- Reset (asynchronous assert): `gpr_addr_w`=0, `gpr_data_w`=0, queue empty, `lsu_pending`=0. Outputs `alu_ready`=1 and `lsu_ready`=1 follow from the empty state.
- Reset mid-operation discards all queued and staged results; no write is emitted.
- Latency: a result accepted at edge N appears on `gpr_*` after edge N and is committed into the register file at edge N+1.
- Peak throughput: one write per cycle.
- A queued load waits at most as long as ALU results keep arriving, and no longer than until the queue fills. Once full, it drains on the next cycle.
- `lsu_pending` is registered: it reflects occupancy after the edge.

## Configuration
- `GPR_WB_FWD_EN` defined adds these ports:
  - `fwd_addr1`, `fwd_addr2` in RW
  - `fwd_hit1`, `fwd_hit2` out 1
  - `fwd_data1`, `fwd_data2` out XLEN
- `fwd_hitN` = (`fwd_addrN`≠0) AND (`fwd_addrN`==`gpr_addr_w`), combinational. `fwd_dataN` = `gpr_data_w`.
- Readers use this to bypass a value staged but not yet written, since the register file returns old data for the same-cycle address.
- Undefined: these ports and their logic are absent, and readers stall on `lsu_pending` / in-flight writes instead.

## Structure
- Package `gpr_wb_pkg` holds:
  - typedef `gpr_wb_entry_t` {live, rd, data}
  - localparam `RW`
  - reset constant `GPR_WB_IDLE` = {0, 0, 0}
- Sub-module `gpr_wb_fifo`: DEPTH-entry circular queue with per-entry rd compare and `live` clear (squash input: valid + rd), push/pop, full/empty. The top level holds arbitration, staging and forwarding.

## Test plan
- ALU only: `alu_rd`=5, `alu_data`=0x11 for one cycle → next cycle `gpr_addr_w`=5, `gpr_data_w`=0x11; the cycle after, `gpr_addr_w`=0.
- LSU during continuous ALU traffic, DEPTH=2: loads to x6, x7 fill the queue → `alu_ready`=0 for one cycle, staged output x6; then x7 drains next.
- Squash: load to x8 (0xAA) queued, then ALU write x8 (0xBB) → only x8=0xBB is emitted. The dead slot later drains with `gpr_addr_w`=0.
- x0 writes: `lsu_rd`=0 and `alu_rd`=0 accepted → `gpr_addr_w` stays 0, and `lsu_pending` stays 0.
- Full + simultaneous push/pop: queue full, `lsu_valid`=1 → `lsu_ready`=1, occupancy unchanged, head emitted.
- Reset with 2 queued entries → outputs 0 immediately, no write after release. With `GPR_WB_FWD_EN`, `fwd_addr1`=5 while x5 is staged → `fwd_hit1`=1, `fwd_data1`=0x11.
